// File: rtl/ltc25xx_pkg.sv
// ---------------------------------------------------------------------------
// ltc25xx_pkg
// Shared definitions for the LTC25xx oversampling SAR ADC behavioural model:
//   - state_e     : conversion FSM states
//   - MODE_NL     : no-latency output mode
//   - MODE_FILT   : averaged (filtered) output mode
//   - clamp_df()  : limits a requested averaging exponent to the supported max
// ---------------------------------------------------------------------------
package ltc25xx_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  localparam logic MODE_NL   = 1'b0;
  localparam logic MODE_FILT = 1'b1;

  // Requests above the supported maximum are treated as the maximum.
  function automatic int unsigned clamp_df(input int unsigned df,
                                           input int unsigned max_df);
    int unsigned res;
    if (df > max_df) begin
      res = max_df;
    end else begin
      res = df;
    end
    return res;
  endfunction

endpackage

// File: rtl/ltc25xx_adc_model_shift_out.sv
// ---------------------------------------------------------------------------
// ltc25xx_shift_out
// Serial output stage: holds the result word, shifts it out MSB-first on each
// detected sck edge and drives sdo from a register.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   load      : load word/nbits this cycle (takes priority over sck_edge)
//   word      : left-justified result word
//   nbits     : number of valid bits to present on sdo
//   sck_edge  : one-cycle pulse per synchronised sck rising edge
//   sdo       : current output bit, 0 once all bits have been shifted out
// ---------------------------------------------------------------------------
module ltc25xx_shift_out
  import ltc25xx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NB_W       = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [NB_W-1:0]       nbits,
  input  logic                  sck_edge,
  output logic                  sdo
);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [NB_W-1:0]       cnt_q, cnt_d;
  logic                  sdo_q, sdo_d;

  // Next-state logic for the shift register, remaining bit count and sdo.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    sdo_d = sdo_q;
    if (load) begin
      // A load restarts the read even if one is in progress; a coincident
      // sck edge is dropped.
      sr_d  = word;
      cnt_d = nbits;
      if (nbits != {NB_W{1'b0}}) begin
        sdo_d = word[DATA_WIDTH-1];
      end else begin
        sdo_d = 1'b0;
      end
    end else if (sck_edge && (cnt_q != {NB_W{1'b0}})) begin
      sr_d  = {sr_q[DATA_WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - NB_W'(1);
      // The bit following the MSB becomes visible unless this was the last.
      if (cnt_q > NB_W'(1)) begin
        sdo_d = sr_q[DATA_WIDTH-2];
      end else begin
        sdo_d = 1'b0;
      end
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      sdo_d = sdo_q;
    end
  end

  // Shift-out state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= {DATA_WIDTH{1'b0}};
      cnt_q <= {NB_W{1'b0}};
      sdo_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      sdo_q <= sdo_d;
    end
  end

  assign sdo = sdo_q;

endmodule

// File: rtl/ltc25xx_adc_model.sv
// ---------------------------------------------------------------------------
// ltc25xx_adc_model
// Clocked behavioural model of an LTC25xx oversampling SAR ADC.
// Ports:
//   clk            : system clock
//   rst            : synchronous active-high reset
//   analog_data_in : two's-complement input value, captured at conversion start
//   convert        : asynchronous conversion request (rising edge)
//   sck            : asynchronous serial clock from the controller
//   mode           : 0 = no-latency word, 1 = averaged word
//   df_log2        : log2 of the averaging factor (clamped to MAX_DF_LOG2)
//   busy           : high while a conversion is in progress
//   drl            : active-low data ready
//   sdo            : serial data, MSB first
//   conv_err       : sticky, set by a convert edge during a conversion
// ---------------------------------------------------------------------------
module ltc25xx_adc_model
  import ltc25xx_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NL_WIDTH    = 24,
  parameter int CONV_CYCLES = 50,
  parameter int MAX_DF_LOG2 = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH-1:0]                analog_data_in,
  input  logic                                 convert,
  input  logic                                 sck,
  input  logic                                 mode,
  input  logic [$clog2(MAX_DF_LOG2+1)-1:0]     df_log2,
  output logic                                 busy,
  output logic                                 drl,
  output logic                                 sdo,
  output logic                                 conv_err
);

  localparam int NB_W  = $clog2(DATA_WIDTH + 1);
  localparam int DF_W  = $clog2(MAX_DF_LOG2 + 1);
  localparam int ACC_W = DATA_WIDTH + MAX_DF_LOG2;
  localparam int CNT_W = $clog2(CONV_CYCLES + 1);
  localparam int AVG_W = MAX_DF_LOG2 + 1;

  // Synchronisers and edge-detect history for the asynchronous inputs.
  logic conv_s1_q, conv_s1_d, conv_s2_q, conv_s2_d, conv_h_q, conv_h_d;
  logic sck_s1_q,  sck_s1_d,  sck_s2_q,  sck_s2_d,  sck_h_q,  sck_h_d;
  logic conv_edge_s, sck_edge_s;

  // Conversion FSM and captured conversion parameters.
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cyc_q, cyc_d;
  logic                    busy_q, busy_d;
  logic                    drl_q, drl_d;
  logic                    conv_err_q, conv_err_d;
  logic [DATA_WIDTH-1:0]   sample_q, sample_d;
  logic                    mode_q, mode_d;
  logic [DF_W-1:0]         df_q, df_d;

  // Averaging accumulator and the number of samples it currently holds.
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [AVG_W-1:0]        count_q, count_d;

  logic [DF_W-1:0]         df_clamped_s;
  logic [ACC_W-1:0]        acc_sum_s;
  logic [AVG_W-1:0]        count_inc_s;
  logic [AVG_W-1:0]        window_s;

  logic                    load_s;
  logic [DATA_WIDTH-1:0]   word_s;
  logic [NB_W-1:0]         nbits_s;

  // Next values of the two-flop synchronisers and history flops.
  always_comb begin
    conv_s1_d = convert;
    conv_s2_d = conv_s1_q;
    conv_h_d  = conv_s2_q;
    sck_s1_d  = sck;
    sck_s2_d  = sck_s1_q;
    sck_h_d   = sck_s2_q;
  end

  assign conv_edge_s = conv_s2_q & ~conv_h_q;
  assign sck_edge_s  = sck_s2_q & ~sck_h_q;

  assign df_clamped_s = DF_W'(clamp_df(32'(df_log2), 32'(MAX_DF_LOG2)));
  assign acc_sum_s    = acc_q + {{MAX_DF_LOG2{sample_q[DATA_WIDTH-1]}}, sample_q};
  assign count_inc_s  = count_q + AVG_W'(1);
  assign window_s     = AVG_W'(1) << df_q;

  // Conversion FSM, averaging and result-load decisions.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    busy_d     = busy_q;
    conv_err_d = conv_err_q;
    sample_d   = sample_q;
    mode_d     = mode_q;
    df_d       = df_q;
    acc_d      = acc_q;
    count_d    = count_q;
    load_s     = 1'b0;
    word_s     = {DATA_WIDTH{1'b0}};
    nbits_s    = {NB_W{1'b0}};

    // The first sck edge after data-ready acknowledges it.
    if (sck_edge_s) begin
      drl_d = 1'b1;
    end else begin
      drl_d = drl_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (conv_edge_s) begin
          sample_d = analog_data_in;
          mode_d   = mode;
          df_d     = df_clamped_s;
          busy_d   = 1'b1;
          drl_d    = 1'b1;
          cyc_d    = CNT_W'(CONV_CYCLES - 1);
          state_d  = ST_CONV;
          // A new mode or factor starts a fresh averaging window.
          if ((mode != mode_q) || (df_clamped_s != df_q)) begin
            acc_d   = {ACC_W{1'b0}};
            count_d = {AVG_W{1'b0}};
          end else begin
            acc_d   = acc_q;
            count_d = count_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CONV: begin
        if (conv_edge_s) begin
          conv_err_d = 1'b1;
        end else begin
          conv_err_d = conv_err_q;
        end

        if (cyc_q == {CNT_W{1'b0}}) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          case (mode_q)
            MODE_NL: begin
              load_s  = 1'b1;
              word_s  = {sample_q[DATA_WIDTH-1 -: NL_WIDTH],
                         {(DATA_WIDTH-NL_WIDTH){1'b0}}};
              nbits_s = NB_W'(NL_WIDTH);
              drl_d   = 1'b0;
            end
            MODE_FILT: begin
              if (count_inc_s == window_s) begin
                load_s  = 1'b1;
                // Arithmetic shift floors the mean towards minus infinity.
                word_s  = DATA_WIDTH'($signed(acc_sum_s) >>> df_q);
                nbits_s = NB_W'(DATA_WIDTH);
                drl_d   = 1'b0;
                acc_d   = {ACC_W{1'b0}};
                count_d = {AVG_W{1'b0}};
              end else begin
                acc_d   = acc_sum_s;
                count_d = count_inc_s;
              end
            end
            default: begin
              load_s = 1'b0;
            end
          endcase
        end else begin
          cyc_d = cyc_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Synchroniser, FSM and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_s1_q  <= 1'b0;
      conv_s2_q  <= 1'b0;
      conv_h_q   <= 1'b0;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_h_q    <= 1'b0;
      state_q    <= ST_IDLE;
      cyc_q      <= {CNT_W{1'b0}};
      busy_q     <= 1'b0;
      drl_q      <= 1'b1;
      conv_err_q <= 1'b0;
      sample_q   <= {DATA_WIDTH{1'b0}};
      mode_q     <= MODE_NL;
      df_q       <= {DF_W{1'b0}};
      acc_q      <= {ACC_W{1'b0}};
      count_q    <= {AVG_W{1'b0}};
    end else begin
      conv_s1_q  <= conv_s1_d;
      conv_s2_q  <= conv_s2_d;
      conv_h_q   <= conv_h_d;
      sck_s1_q   <= sck_s1_d;
      sck_s2_q   <= sck_s2_d;
      sck_h_q    <= sck_h_d;
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      busy_q     <= busy_d;
      drl_q      <= drl_d;
      conv_err_q <= conv_err_d;
      sample_q   <= sample_d;
      mode_q     <= mode_d;
      df_q       <= df_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
    end
  end

  ltc25xx_shift_out #(
    .DATA_WIDTH (DATA_WIDTH),
    .NB_W       (NB_W)
  ) u_shift_out (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .word     (word_s),
    .nbits    (nbits_s),
    .sck_edge (sck_edge_s),
    .sdo      (sdo)
  );

  assign busy     = busy_q;
  assign drl      = drl_q;
  assign conv_err = conv_err_q;

endmodule

// File: tb/tb_ltc25xx_adc_model.sv
// ---------------------------------------------------------------------------
// tb_ltc25xx_adc_model
// Directed, table-driven bench for ltc25xx_adc_model with default parameters.
// ---------------------------------------------------------------------------
module tb_ltc25xx_adc_model;

  localparam int DW = 32;
  localparam int CC = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          convert;
  logic          sck;
  logic          mode;
  logic [2:0]    df;
  logic          busy, drl, sdo, conv_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        m;
    logic [2:0]  f;
    logic [31:0] d;
    logic        out;
    logic [31:0] w;
    int          nb;
  } vec_t;

  localparam int NV = 12;
  vec_t tv [NV];

  always #5 clk = ~clk;

  ltc25xx_adc_model #(
    .DATA_WIDTH  (32),
    .NL_WIDTH    (24),
    .CONV_CYCLES (CC),
    .MAX_DF_LOG2 (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .analog_data_in (din),
    .convert        (convert),
    .sck            (sck),
    .mode           (mode),
    .df_log2        (df),
    .busy           (busy),
    .drl            (drl),
    .sdo            (sdo),
    .conv_err       (conv_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic sck_pulse();
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Starts a conversion; optionally pulses convert again at busy cycle err_at
  // or asserts reset at busy cycle rst_at (use -1 to disable either).
  task automatic do_convert(input logic [31:0] d, input logic m, input logic [2:0] f,
                            input int err_at, input int rst_at);
    int hi;
    @(negedge clk);
    din = d; mode = m; df = f; convert = 1'b1;
    @(negedge clk);
    check("busy_pre1", busy, 1'b0);
    @(negedge clk);
    check("busy_pre2", busy, 1'b0);
    convert = 1'b0;
    @(negedge clk);
    check("busy_rise", busy, 1'b1);
    hi = 1;
    while ((busy === 1'b1) && (hi < 200)) begin
      if (hi == err_at) convert = 1'b1;
      if (hi == err_at + 2) convert = 1'b0;
      if (hi == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_drl", drl, 1'b1);
        return;
      end
      @(negedge clk);
      hi++;
    end
    check("busy_len", hi - 1, CC);
  endtask

  task automatic read_word(input string tag, input logic [31:0] exp, input int nb);
    logic [31:0] got;
    got = 32'h0;
    for (int b = 0; b < nb; b++) begin
      got = {got[30:0], sdo};
      sck_pulse();
      if (b == 0) check({tag, "_drl_release"}, drl, 1'b1);
    end
    check({tag, "_word"}, got, exp);
    check({tag, "_tail"}, sdo, 1'b0);
    sck_pulse();
    check({tag, "_tail2"}, sdo, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen;
    int drl_low_seen;

    tv[0]  = '{1'b0, 3'd0, 32'h89ABCDEF, 1'b1, 32'h0089ABCD, 24};
    tv[1]  = '{1'b1, 3'd2, 32'd100,      1'b0, 32'h0,        0};
    tv[2]  = '{1'b1, 3'd2, 32'd200,      1'b0, 32'h0,        0};
    tv[3]  = '{1'b1, 3'd2, 32'd300,      1'b0, 32'h0,        0};
    tv[4]  = '{1'b1, 3'd2, 32'd400,      1'b1, 32'd250,      32};
    tv[5]  = '{1'b1, 3'd1, 32'hFFFFFFFD, 1'b0, 32'h0,        0};
    tv[6]  = '{1'b1, 3'd1, 32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC, 32};
    tv[7]  = '{1'b1, 3'd2, 32'd10,       1'b0, 32'h0,        0};
    tv[8]  = '{1'b1, 3'd2, 32'd20,       1'b0, 32'h0,        0};
    tv[9]  = '{1'b1, 3'd0, 32'd7,        1'b1, 32'd7,        32};
    tv[10] = '{1'b0, 3'd0, 32'h80000001, 1'b1, 32'h00800000, 24};
    tv[11] = '{1'b1, 3'd0, 32'hFFFFFF9C, 1'b1, 32'hFFFFFF9C, 32};

    rst = 1'b1; din = 32'h0; convert = 1'b0; sck = 1'b0; mode = 1'b0; df = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_drl", drl, 1'b1);
    check("reset_sdo", sdo, 1'b0);
    check("reset_conv_err", conv_err, 1'b0);

    // Table of single conversions with the expected data-ready and word.
    for (int i = 0; i < NV; i++) begin
      do_convert(tv[i].d, tv[i].m, tv[i].f, -1, -1);
      check($sformatf("v%0d_drl", i), drl, tv[i].out ? 1'b0 : 1'b1);
      if (tv[i].out) read_word($sformatf("v%0d", i), tv[i].w, tv[i].nb);
    end
    check("no_err_yet", conv_err, 1'b0);

    // Factor 7 clamps to 16-sample averaging: mean of 1..16 = 8.5 -> 8.
    for (int i = 0; i < 16; i++) begin
      do_convert(32'(i + 1), 1'b1, 3'd7, -1, -1);
      check($sformatf("clamp%0d_drl", i), drl, (i == 15) ? 1'b0 : 1'b1);
    end
    read_word("clamp", 32'd8, 32);

    // Convert edge while busy: timing unchanged, sticky error, single load.
    do_convert(32'h12345678, 1'b0, 3'd0, 10, -1);
    check("err_flag", conv_err, 1'b1);
    check("err_drl", drl, 1'b0);
    busy_seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("err_no_extra_conv", busy_seen, 0);
    read_word("err", 32'h00123456, 24);
    check("err_sticky", conv_err, 1'b1);

    // Reset in the middle of a conversion aborts it without a load.
    do_convert(32'hCAFEBABE, 1'b0, 3'd0, -1, 20);
    check("rst_clears_err", conv_err, 1'b0);
    busy_seen = 0;
    drl_low_seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (!drl) drl_low_seen++;
    end
    check("rst_no_busy", busy_seen, 0);
    check("rst_no_drl", drl_low_seen, 0);
    check("rst_sdo", sdo, 1'b0);
    do_convert(32'h0F1E2D3C, 1'b0, 3'd0, -1, -1);
    check("post_rst_drl", drl, 1'b0);
    read_word("post_rst", 32'h000F1E2D, 24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
